// File: rtl/rect_move_ctl_pkg.sv
// rect_move_ctl_pkg: display geometry and the obstacle-motion state type.
package rect_move_ctl_pkg;
    localparam int HOR_PIXELS = 800;
    localparam int VER_PIXELS = 600;
    typedef enum logic [1:0] {IDLE, ARMED, RUN, HALT} rect_move_state_t;
endpackage

// File: rtl/vga_if.sv
// vga_if: timing bus between display pipeline stages; this slice carries vblnk only.
interface vga_if;
    logic vblnk;
    modport in (input vblnk);
    modport out (output vblnk);
endinterface

// File: rtl/rect_move_ctl_vblnk_edge_det.sv
// vblnk_edge_det: registers vblnk and emits a one-cycle pulse on its rising edge.
module vblnk_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic level_i,
    output logic pulse_o
);
    logic level_q;
    always_ff @(posedge clk) begin
        if (rst) level_q <= 1'b0;
        else     level_q <= level_i;
    end
    assign pulse_o = level_i & ~level_q;
endmodule

// File: rtl/rect_move_ctl.sv
// rect_move_ctl: frame-aligned horizontal obstacle mover; wraps at the edges by default,
// bounces when RECT_MOVE_BOUNCE_EN is defined.
module rect_move_ctl
    import rect_move_ctl_pkg::*;
#(
    parameter int RECT_W = 100,
    parameter int X_INIT = 0,
    parameter int Y_INIT = 250
) (
    input  logic        clk,
    input  logic        rst,
    vga_if.in           vga_in,
    input  logic        start,
    input  logic        stop,
    input  logic        load,
    input  logic [11:0] x_load,
    input  logic [11:0] y_load,
    input  logic [3:0]  speed,
    output logic [11:0] xpos_rect,
    output logic [11:0] ypos_rect,
    output logic        moving,
    output logic        dir_left
);
    localparam logic [12:0] XMAX = 13'(HOR_PIXELS - RECT_W);
    rect_move_state_t state_q, state_d;
    logic [11:0] x_q, x_d, y_q, y_d;
    logic        dir_q, dir_d, tick;
    logic [12:0] x13, spd13, sum, dif;

    vblnk_edge_det u_edge (.clk(clk), .rst(rst), .level_i(vga_in.vblnk), .pulse_o(tick));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= 12'(X_INIT);
            y_q     <= 12'(Y_INIT);
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dir_q   <= dir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  state_d = (start && !stop) ? ARMED : IDLE;
            ARMED: state_d = stop ? IDLE : (tick ? RUN : ARMED);
            RUN:   state_d = stop ? HALT : RUN;
            HALT:  state_d = tick ? IDLE : HALT;
            default: state_d = IDLE;
        endcase
        if (load) state_d = IDLE;
    end

    // Differences are 13 b so an underflow shows up in the compare before truncation.
    always_comb begin
        x13   = {1'b0, x_q};
        spd13 = {9'b0, speed};
        sum   = x13 + spd13;
        dif   = x13 - spd13;
        x_d   = x_q;
        y_d   = y_q;
        dir_d = dir_q;
        if (load) begin
            x_d   = ({1'b0, x_load} > XMAX) ? XMAX[11:0] : x_load;
            y_d   = y_load;
            dir_d = 1'b0;
        end else if (state_q == RUN && tick) begin
`ifdef RECT_MOVE_BOUNCE_EN
            if (!dir_q) {dir_d, x_d} = (sum >= XMAX) ? {1'b1, XMAX[11:0]} : {1'b0, sum[11:0]};
            else        {dir_d, x_d} = (x13 <= spd13) ? 13'd0 : {1'b1, dif[11:0]};
`else
            x_d = dir_q ? ((x13 < spd13) ? XMAX[11:0] : dif[11:0])
                        : ((sum > XMAX) ? 12'd0 : sum[11:0]);
`endif
        end
    end

    always_comb begin
        moving = (state_q == RUN) || (state_q == HALT);
    end

    assign xpos_rect = x_q;
    assign ypos_rect = y_q;
    assign dir_left  = dir_q;
endmodule

// File: tb/tb_rect_move_ctl.sv
// tb_rect_move_ctl: directed stimulus, per-cycle check against a behavioural model plus literal pins.
module tb_rect_move_ctl;
    localparam int XMAX = 700;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0, stop = 1'b0, load = 1'b0;
    logic [11:0] x_load = '0, y_load = '0;
    logic [3:0]  speed = '0;
    logic [11:0] xpos_rect, ypos_rect;
    logic        moving, dir_left;
    int n_chk = 0, n_fail = 0;
    bit checking = 0;

    vga_if vif ();
    initial vif.vblnk = 1'b0;
    always #5 clk = ~clk;

    rect_move_ctl dut (
        .clk(clk), .rst(rst), .vga_in(vif), .start(start), .stop(stop), .load(load),
        .x_load(x_load), .y_load(y_load), .speed(speed), .xpos_rect(xpos_rect),
        .ypos_rect(ypos_rect), .moving(moving), .dir_left(dir_left)
    );

    // Behavioural model: motion phase as plain flags, position as integers.
    int  mx, my;
    bit  mdir, armed, running, halting, pv;
    always @(posedge clk) begin
        bit tk;
        int sp;
        tk = vif.vblnk && !pv;
        sp = int'(speed);
        pv <= vif.vblnk;
        if (rst) begin
            mx <= 0; my <= 250; mdir <= 0; armed <= 0; running <= 0; halting <= 0; pv <= 0;
        end else if (load) begin
            mx <= (int'(x_load) > XMAX) ? XMAX : int'(x_load);
            my <= int'(y_load); mdir <= 0; armed <= 0; running <= 0; halting <= 0;
        end else begin
            if (running && tk) begin
`ifdef RECT_MOVE_BOUNCE_EN
                if (!mdir) begin
                    if (mx + sp >= XMAX) begin mx <= XMAX; mdir <= 1; end else mx <= mx + sp;
                end else begin
                    if (mx <= sp) begin mx <= 0; mdir <= 0; end else mx <= mx - sp;
                end
`else
                mx <= (mx + sp > XMAX) ? 0 : mx + sp;
`endif
            end
            if (halting && tk) halting <= 0;
            if (running && stop) begin running <= 0; halting <= 1; end
            if (armed) begin
                if (stop) armed <= 0;
                else if (tk) begin armed <= 0; running <= 1; end
            end
            if (!armed && !running && !halting && start && !stop) armed <= 1;
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            n_chk++;
            if (int'(xpos_rect) != mx || int'(ypos_rect) != my || moving != (running || halting)
                || dir_left != mdir) begin
                n_fail++;
                $display("FAIL model t=%0t x=%0d y=%0d mv=%0b dl=%0b required x=%0d y=%0d mv=%0b dl=%0b",
                         $time, xpos_rect, ypos_rect, moving, dir_left, mx, my,
                         running || halting, mdir);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        @(negedge clk);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame();
        vif.vblnk = 1'b1; step(3);
        vif.vblnk = 1'b0; step(6);
    endtask

    initial begin
        step(2);
        rst = 1'b0;
        checking = 1;
        chk("reset_x", int'(xpos_rect), 0);
        chk("reset_y", int'(ypos_rect), 250);
        chk("reset_moving", int'(moving), 0);
        chk("reset_dir", int'(dir_left), 0);
        frame(); frame();
        chk("idle_ticks_x", int'(xpos_rect), 0);

        speed = 4;
        start = 1; step(1); start = 0;
        chk("armed_not_moving", int'(moving), 0);
        frame();
        chk("run_after_tick1_x", int'(xpos_rect), 0);
        chk("run_moving", int'(moving), 1);
        frame(); chk("tick2_x", int'(xpos_rect), 4);
        frame(); chk("tick3_x", int'(xpos_rect), 8);
        frame(); step(2); chk("tick4_x_held", int'(xpos_rect), 12);

        x_load = 12'd698; y_load = 12'd250;
        load = 1; step(1); load = 0;
        chk("load_x", int'(xpos_rect), 698);
        chk("load_idle", int'(moving), 0);
        speed = 5;
        start = 1; step(1); start = 0;
        frame(); frame();
`ifdef RECT_MOVE_BOUNCE_EN
        chk("bounce_right_x", int'(xpos_rect), XMAX);
        chk("bounce_right_dir", int'(dir_left), 1);
        frame(); chk("bounce_back_x", int'(xpos_rect), XMAX - 5);
        speed = 15;
        for (int i = 0; i < 60 && dir_left; i++) frame();
        chk("bounce_left_x", int'(xpos_rect), 0);
        chk("bounce_left_dir", int'(dir_left), 0);
        speed = 5;
`else
        chk("wrap_x", int'(xpos_rect), 0);
        chk("wrap_dir", int'(dir_left), 0);
        frame(); chk("after_wrap_x", int'(xpos_rect), 5);
`endif

        stop = 1; step(1); stop = 0;
        chk("halt_still_moving", int'(moving), 1);
        frame();
        chk("halt_done", int'(moving), 0);

        start = 1; stop = 1; step(1); start = 0; stop = 0;
        frame();
        chk("start_stop_idle", int'(moving), 0);
        start = 1; step(1); start = 0;
        stop = 1; step(1); stop = 0;
        frame();
        chk("armed_stop_idle", int'(moving), 0);

        start = 1; step(1); start = 0;
        frame(); frame();
        step(1);
        x_load = 12'd900; y_load = 12'd123;
        load = 1; step(1); load = 0;
        chk("load_clamp_x", int'(xpos_rect), XMAX);
        chk("load_y", int'(ypos_rect), 123);
        chk("load_run_idle", int'(moving), 0);
        frame();
        chk("idle_after_load_x", int'(xpos_rect), XMAX);

        step(2);
        checking = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
